// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared types, constants and helpers for the timer_ar block.
// Revision : 1.0  initial release
// ============================================================================
package timer_pkg;

  // Legal parameter ranges for timer_ar.
  localparam int C_WIDTH_MIN = 2;
  localparam int C_WIDTH_MAX = 32;
  localparam int C_CKS_W_MIN = 1;
  localparam int C_CKS_W_MAX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  // Terminal prescaler count for a select value: 2^(sel+1) - 1.
  // Eight bits hold the largest case (sel = 7 -> 255).
  function automatic logic [7:0] prescale_max(input logic [2:0] sel);
    return 8'((9'd2 << sel) - 9'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_prescaler
// Brief    : Free-running divider that emits one tick every 2^(cks+1)
//            cycles while the timer is running.
// Revision : 1.0  initial release
// ============================================================================
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int CKS_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [CKS_W-1:0] cks,
  output logic             tick
);

  localparam int C_PW = 1 << CKS_W;

  logic [C_PW-1:0] r_cnt;
  logic            w_at_scale;

  // ">=" lets a lowered select take effect at once instead of wrapping around.
  assign w_at_scale = (8'(r_cnt) >= prescale_max(3'(cks)));
  assign tick       = run && w_at_scale;

  // Divider count: restarts when idle, on load, or after reaching the scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || !run || w_at_scale) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_ar.sv
`default_nettype none
// ============================================================================
// Module   : timer_ar
// Brief    : Parametrised prescaled up/down timer with auto-reload,
//            one-shot mode and compare-match pulse.
// Revision : 1.0  initial release
// ============================================================================
module timer_ar
  import timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CKS_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] reload,
  input  logic [WIDTH-1:0] cmp,
  input  logic             en,
  input  logic             up_dw,
  input  logic             one_shot,
  input  logic [CKS_W-1:0] cks,
  output logic [WIDTH-1:0] tcnt,
  output logic             ovf,
  output logic             udf,
  output logic             cmp_match,
  output logic             clock_tick,
  output logic             running
);

  timer_state_e     r_state;
  timer_state_e     w_state_next;
  logic             w_run;
  logic             w_tick;
  logic             w_wrap;
  logic             w_count;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next_cnt;
  logic [WIDTH-1:0] r_tcnt;
  logic             r_ovf;
  logic             r_udf;
  logic             r_cmp_match;

  assign w_run = (r_state == RUN);

  timer_prescaler #(
    .CKS_W (CKS_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .run  (w_run),
    .cks  (cks),
    .tick (w_tick)
  );

  // Wrap happens at the end of the range in the current direction.
  assign w_wrap     = up_dw ? (r_tcnt == '0) : (&r_tcnt);
  assign w_step     = up_dw ? (r_tcnt - WIDTH'(1)) : (r_tcnt + WIDTH'(1));
  assign w_next_cnt = w_wrap ? reload : w_step;
  // A load in the same cycle discards the tick.
  assign w_count    = w_tick && !load;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; dropping en always wins.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (en) w_state_next = RUN;
      RUN: begin
        if (!en)                                w_state_next = IDLE;
        else if (w_count && w_wrap && one_shot) w_state_next = DONE;
      end
      DONE: begin
        if (!en)       w_state_next = IDLE;
        else if (load) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counter and event flags; flags are single-cycle pulses aligned with tcnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt      <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_cmp_match <= 1'b0;
    end else begin
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_cmp_match <= 1'b0;
      if (load) begin
        r_tcnt <= data;
      end else if (w_count) begin
        r_tcnt      <= w_next_cnt;
        r_ovf       <= w_wrap && !up_dw;
        r_udf       <= w_wrap && up_dw;
        r_cmp_match <= (w_next_cnt == cmp);
      end
    end
  end

  assign tcnt       = r_tcnt;
  assign ovf        = r_ovf;
  assign udf        = r_udf;
  assign cmp_match  = r_cmp_match;
  assign clock_tick = w_tick;
  assign running    = w_run;

endmodule
`default_nettype wire
